serial_add_ctrl: RTL

Bit-serial adder controller. It computes a WIDTH-bit sum by sequencing one instance of the existing 1-bit full adder `fa` over WIDTH clock cycles, LSB first. It sits wherever an area-minimal adder is needed and latency is acceptable. It captures operands on a start request, runs the carry chain through a registered carry, then presents a held result with a one-cycle done pulse.

---
 rtl/serial_add_pkg.sv | 18 +
 rtl/serial_add_fa.sv | 16 +
 rtl/serial_add_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default operand width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_e;

endpackage

// File: rtl/serial_add_fa.sv
// 1-bit full adder, the arithmetic cell reused every cycle by the serial adder.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b, cin -> sum, carry.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one fa cell sequenced LSB-first over WIDTH cycles.
// Latency: WIDTH+1 edges from accepted start to the done pulse; one result per WIDTH+1 cycles.
// Backpressure: start is ignored while busy; accepted in IDLE or in the DONE cycle.
// Ports: clk, rst (sync, active high), start, a, b, cin -> busy, done, sum, cout.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Only WIDTH-1 partial bits are ever stored; the final bit comes straight
    // from the adder on the last RUN edge.
    logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_full;

    fa u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New bit enters at the MSB; after WIDTH edges bit 0 has reached position 0.
    assign sum_full = {fa_sum, sum_sh_q};

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        case (state_q)
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_full[WIDTH-1:1];
                carry_d  = fa_carry;
                if (cnt_q == CNT_LAST) begin
                    // Final bit: publish the result; counter is left alone so it never wraps.
                    sum_d   = sum_full;
                    cout_d  = fa_carry;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // IDLE and DONE accept start identically, giving back-to-back operation.
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    carry_d  = cin;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
